ifmap_row_packer: RTL and testbench

Upstream feeder for the PE's IFMap buffer. Accepts a stream of 16-bit activation pixels over a valid/ready handshake and tags each pixel with a 2-bit row marker: start, end, middle or single. It packs `PAR_WRITE` tagged words per entry and drives the buffer's parallel write port (`IFMap_in` / `wen_IFMap_buffer`), honouring the buffer-full back-pressure. A short row is padded by replicating its end-tagged last word.

---
 rtl/ifmap_pkg.sv | 32 +++
 rtl/ifmap_row_packer.sv | 112 +++++++++++
 tb/tb_ifmap_row_packer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifmap_pkg.sv
// Shared constants, tagged-word type and row-marker helper for the IFMap row packer.
package ifmap_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned TAG_W  = 2;

  localparam logic [TAG_W-1:0] TAG_START  = 2'b10;
  localparam logic [TAG_W-1:0] TAG_END    = 2'b01;
  localparam logic [TAG_W-1:0] TAG_MID    = 2'b00;
  localparam logic [TAG_W-1:0] TAG_SINGLE = 2'b11;

  // One buffer lane: row marker above the pixel.
  typedef struct packed {
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] pix;
  } tagged_word_t;

  // Row marker for pixel position idx in a row of len pixels (len already clamped to >= 1).
  function automatic logic [TAG_W-1:0] calc_tag(input int unsigned idx, input int unsigned len);
    logic [TAG_W-1:0] tag;
    tag = TAG_MID;
    if (len <= 1) begin
      tag = TAG_SINGLE;
    end else if (idx == 0) begin
      tag = TAG_START;
    end else if (idx == len - 1) begin
      tag = TAG_END;
    end
    return tag;
  endfunction

endpackage

// File: rtl/ifmap_row_packer.sv
// Tags incoming pixels with row markers and packs PAR_WRITE of them per IFMap buffer write.
module ifmap_row_packer
  import ifmap_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned TAG_WIDTH    = 2,
  parameter int unsigned PAR_WRITE    = 4,
  parameter int unsigned ROW_LEN_SIZE = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     chip_en,
  input  logic [ROW_LEN_SIZE-1:0]                  row_len,
  input  logic [DATA_WIDTH-1:0]                    pix_in,
  input  logic                                     pix_valid,
  output logic                                     pix_ready,
  input  logic                                     buf_full,
  output logic [PAR_WRITE*(DATA_WIDTH+TAG_WIDTH)-1:0] IFMap_in,
  output logic                                     wen_IFMap_buffer,
  output logic                                     row_done
);

  localparam int unsigned WORD_W  = DATA_WIDTH + TAG_WIDTH;
  localparam int unsigned ENTRY_W = PAR_WRITE * WORD_W;
  localparam int unsigned LANE_W  = (PAR_WRITE > 1) ? $clog2(PAR_WRITE) : 1;
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(PAR_WRITE - 1);

  logic [ROW_LEN_SIZE-1:0] pix_cnt;
  logic [ROW_LEN_SIZE-1:0] row_len_q;
  logic [ROW_LEN_SIZE-1:0] eff_len;
  logic [LANE_W-1:0]       lane_cnt;
  logic [WORD_W-1:0]       acc [PAR_WRITE];
  logic [ENTRY_W-1:0]      out_q;
  logic [ENTRY_W-1:0]      group_c;
  logic                    out_valid;
  logic                    out_last;
  logic [TAG_WIDTH-1:0]    tag_c;
  logic [WORD_W-1:0]       word_c;
  logic                    accept;
  logic                    write;
  logic                    is_last;
  logic                    group_done;

  // Row length in force: live (clamped) value on a row's first pixel, latched value afterwards.
  always_comb begin
    eff_len = row_len_q;
    if (pix_cnt == '0) begin
      eff_len = (row_len == '0) ? ROW_LEN_SIZE'(1) : row_len;
    end
  end

  assign is_last    = (pix_cnt == eff_len - ROW_LEN_SIZE'(1));
  assign tag_c      = TAG_WIDTH'(calc_tag(32'(pix_cnt), 32'(eff_len)));
  assign word_c     = {tag_c, pix_in};

  // Handshakes are combinational so back-pressure acts in the same cycle.
  assign pix_ready        = rst && chip_en && (!out_valid || !buf_full);
  assign accept           = pix_valid && pix_ready;
  assign write            = out_valid && !buf_full && chip_en;
  assign group_done       = accept && (is_last || (lane_cnt == LAST_LANE));
  assign wen_IFMap_buffer = write;
  assign row_done         = write && out_last;
  assign IFMap_in         = out_q;

  // Completed entry: earlier lanes from the accumulator, current lane and any lanes above it
  // take the new word, which pads a short row with its end-tagged last pixel.
  for (genvar i = 0; i < PAR_WRITE; i++) begin : g_lane
    assign group_c[i*WORD_W +: WORD_W] = (LANE_W'(i) < lane_cnt) ? acc[i] : word_c;
  end

  // Pixel position, lane position and latched row length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_cnt   <= '0;
      row_len_q <= '0;
      lane_cnt  <= '0;
    end else if (accept) begin
      if (pix_cnt == '0) begin
        row_len_q <= eff_len;
      end
      pix_cnt  <= is_last ? '0 : pix_cnt + ROW_LEN_SIZE'(1);
      lane_cnt <= group_done ? '0 : lane_cnt + LANE_W'(1);
    end
  end

  // Accumulator holding the tagged words of the group in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < PAR_WRITE; i++) begin
        acc[i] <= '0;
      end
    end else if (accept) begin
      acc[lane_cnt] <= word_c;
    end
  end

  // Output entry register; a completion in the same cycle as a write reloads it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_q     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (group_done) begin
      out_q     <= group_c;
      out_valid <= 1'b1;
      out_last  <= is_last;
    end else if (write) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ifmap_row_packer.sv
module tb_ifmap_row_packer;

  localparam int P  = 4;
  localparam int EW = P * 18;

  logic          clk = 1'b0;
  logic          rst;
  logic          chip_en;
  logic [7:0]    row_len;
  logic [15:0]   pix_in;
  logic          pix_valid;
  logic          pix_ready;
  logic          buf_full;
  logic [EW-1:0] IFMap_in;
  logic          wen_IFMap_buffer;
  logic          row_done;

  ifmap_row_packer dut (
    .clk              (clk),
    .rst              (rst),
    .chip_en          (chip_en),
    .row_len          (row_len),
    .pix_in           (pix_in),
    .pix_valid        (pix_valid),
    .pix_ready        (pix_ready),
    .buf_full         (buf_full),
    .IFMap_in         (IFMap_in),
    .wen_IFMap_buffer (wen_IFMap_buffer),
    .row_done         (row_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [EW-1:0] data;
    logic          done;
  } entry_t;

  int n_vec  = 0;
  int n_miss = 0;

  // Model: rows of pixels turned into expected entries.
  entry_t        exp_q[$];
  logic [EW-1:0] m_log[$];
  logic [17:0]   m_grp[$];
  int            m_pos = 0;
  int            m_len = 1;

  task automatic m_accept(input logic [15:0] p, input logic [7:0] rl);
    logic [1:0]    t;
    logic [17:0]   wd;
    bit            last;
    entry_t        e;
    if (m_pos == 0) m_len = (rl == 0) ? 1 : int'(rl);
    last = (m_pos == m_len - 1);
    if (m_len == 1)       t = 2'b11;
    else if (m_pos == 0)  t = 2'b10;
    else if (last)        t = 2'b01;
    else                  t = 2'b00;
    m_grp.push_back({t, p});
    if (m_grp.size() == P || last) begin
      for (int i = 0; i < P; i++) begin
        wd = (i < m_grp.size()) ? m_grp[i] : m_grp[m_grp.size() - 1];
        e.data[i*18 +: 18] = wd;
      end
      e.done = last;
      exp_q.push_back(e);
      m_log.push_back(e.data);
      m_grp.delete();
    end
    m_pos = last ? 0 : m_pos + 1;
  endtask

  // Per-cycle compare of the handshake, write data and row_done against the model.
  always @(negedge clk) begin
    bit pend, e_wen, e_rdy, e_done;
    if (!rst) begin
      exp_q.delete();
      m_grp.delete();
      m_pos = 0;
      n_vec++;
      if (wen_IFMap_buffer !== 1'b0 || pix_ready !== 1'b0 || row_done !== 1'b0 || IFMap_in !== '0) begin
        n_miss++;
        $display("FAIL reset_outputs: got wen=%b rdy=%b done=%b data=%h, want all zero",
                 wen_IFMap_buffer, pix_ready, row_done, IFMap_in);
      end
    end else begin
      pend   = (exp_q.size() != 0);
      e_wen  = pend && !buf_full && chip_en;
      e_rdy  = chip_en && (!pend || !buf_full);
      e_done = e_wen && exp_q[0].done;
      n_vec++;
      if (wen_IFMap_buffer !== e_wen || pix_ready !== e_rdy || row_done !== e_done) begin
        n_miss++;
        $display("FAIL handshake @%0t: got wen=%b rdy=%b done=%b, want wen=%b rdy=%b done=%b",
                 $time, wen_IFMap_buffer, pix_ready, row_done, e_wen, e_rdy, e_done);
      end
      if (e_wen) begin
        if (wen_IFMap_buffer === 1'b1) begin
          n_vec++;
          if (IFMap_in !== exp_q[0].data) begin
            n_miss++;
            $display("FAIL entry_data @%0t: got %h, want %h", $time, IFMap_in, exp_q[0].data);
          end
        end
        void'(exp_q.pop_front());
      end
      if (pix_valid && e_rdy) m_accept(pix_in, row_len);
    end
  end

  function automatic logic [17:0] w(input logic [1:0] t, input int p);
    return {t, 16'(p)};
  endfunction

  function automatic logic [EW-1:0] ent(input logic [17:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic check(input string name, input logic [EW-1:0] got, input logic [EW-1:0] want);
    n_vec++;
    if (got !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, got, want);
    end
  endtask

  task automatic check_log(input string name, input int idx, input logic [EW-1:0] want);
    n_vec++;
    if (idx >= m_log.size()) begin
      n_miss++;
      $display("FAIL %s: got no entry %0d, want %h", name, idx, want);
    end else if (m_log[idx] !== want) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", name, m_log[idx], want);
    end
  endtask

  // Offer one pixel and hold it until accepted (bounded).
  task automatic send(input int p, input int rl);
    int waited;
    pix_in    = 16'(p);
    row_len   = 8'(rl);
    pix_valid = 1'b1;
    waited    = 0;
    forever begin
      @(negedge clk);
      if (pix_ready) break;
      waited++;
      if (waited > 50) begin
        n_vec++;
        n_miss++;
        $display("FAIL send_timeout: got no accept for pixel %0d, want accept within 50 cycles", p);
        break;
      end
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  // Let pending entries drain, then check the model produced the expected count.
  task automatic idle_and_count(input string name, input int n);
    repeat (4) begin @(posedge clk); #1; end
    check({name, "_count"}, EW'(m_log.size()), EW'(n));
    check({name, "_drained"}, EW'(exp_q.size()), EW'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish before 100000");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; chip_en = 1'b1; row_len = 8'd0; pix_in = '0; pix_valid = 1'b0; buf_full = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    n_vec++;
    if (pix_ready !== 1'b1) begin
      n_miss++;
      $display("FAIL ready_after_reset: got %b, want 1", pix_ready);
    end
    @(posedge clk); #1;

    // Seven-pixel row: full group then padded partial group.
    m_log.delete();
    for (int i = 1; i <= 7; i++) send(i, 7);
    idle_and_count("row7", 2);
    check_log("row7_e0", 0, ent(w(2'b00, 4), w(2'b00, 3), w(2'b00, 2), w(2'b10, 1)));
    check_log("row7_e1", 1, ent(w(2'b01, 7), w(2'b01, 7), w(2'b00, 6), w(2'b00, 5)));

    // Exact-fit row with a mid-row row_len change, then a fresh row.
    m_log.delete();
    send(9, 4);
    for (int i = 10; i <= 12; i++) send(i, 7);
    for (int i = 13; i <= 16; i++) send(i, 4);
    idle_and_count("row4", 2);
    check_log("row4_e0", 0, ent(w(2'b01, 12), w(2'b00, 11), w(2'b00, 10), w(2'b10, 9)));
    check_log("row4_e1", 1, ent(w(2'b01, 16), w(2'b00, 15), w(2'b00, 14), w(2'b10, 13)));

    // Single-pixel rows back to back (row_len 1 and row_len 0).
    m_log.delete();
    send(5, 1);
    send(6, 0);
    idle_and_count("single", 2);
    check_log("single_e0", 0, ent(w(2'b11, 5), w(2'b11, 5), w(2'b11, 5), w(2'b11, 5)));
    check_log("single_e1", 1, ent(w(2'b11, 6), w(2'b11, 6), w(2'b11, 6), w(2'b11, 6)));

    // Back-pressure held for five cycles after a completion.
    m_log.delete();
    for (int i = 1; i <= 3; i++) send(i, 4);
    pix_in = 16'd4; row_len = 8'd4; pix_valid = 1'b1; buf_full = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    pix_in = 16'd5;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready", EW'(pix_ready), EW'(0));
      check("bp_wen", EW'(wen_IFMap_buffer), EW'(0));
      check("bp_hold", IFMap_in, ent(w(2'b01, 4), w(2'b00, 3), w(2'b00, 2), w(2'b10, 1)));
      @(posedge clk); #1;
    end
    buf_full = 1'b0;
    @(negedge clk);
    check("bp_release_wen", EW'(wen_IFMap_buffer), EW'(1));
    @(posedge clk); #1;
    pix_valid = 1'b0;
    for (int i = 6; i <= 8; i++) send(i, 4);
    idle_and_count("bp", 2);
    check_log("bp_e0", 0, ent(w(2'b01, 4), w(2'b00, 3), w(2'b00, 2), w(2'b10, 1)));
    check_log("bp_e1", 1, ent(w(2'b01, 8), w(2'b00, 7), w(2'b00, 6), w(2'b10, 5)));

    // Reset in the middle of a row discards the partial group.
    m_log.delete();
    send(1, 7);
    send(2, 7);
    rst = 1'b0;
    @(negedge clk);
    check("async_clear", IFMap_in, '0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 20; i <= 23; i++) send(i, 4);
    idle_and_count("midreset", 1);
    check_log("midreset_e0", 0, ent(w(2'b01, 23), w(2'b00, 22), w(2'b00, 21), w(2'b10, 20)));

    // Freeze mid-group with a pixel offered.
    m_log.delete();
    send(1, 4);
    send(2, 4);
    pix_in = 16'd3; pix_valid = 1'b1; chip_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("freeze_ready", EW'(pix_ready), EW'(0));
      @(posedge clk); #1;
    end
    chip_en = 1'b1;
    send(3, 4);
    send(4, 4);
    idle_and_count("freeze", 1);
    check_log("freeze_e0", 0, ent(w(2'b01, 4), w(2'b00, 3), w(2'b00, 2), w(2'b10, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
